matrix_tx_formatter: RTL and testbench
======================================

Name: matrix_tx_formatter

Overview:
- Reads one stored matrix from Matrix_storage and serialises it as ASCII text bytes for the UART transmitter. It is the encoding counterpart of the input parser, which turns ASCII into stored words.
- Sits between the storage read port (via Storage_Mux display path) and the UART TX byte interface inside the display subsystem.
- Output format: row-major decimal elements, single space between elements, CR LF after each row.

Parameters:
- ADDR_W, 9, storage address width
- DATA_W, 32, storage word width; only bits [15:0] are formatted
- MAX_DIM, 5, maximum legal m and n

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- i_start  in  1  one-cycle start pulse; ignored unless idle
- i_base_addr  in  9  storage address of element (0,0)
- i_m  in  3  row count
- i_n  in  3  column count
- o_rd_addr  out  9  storage read address
- i_rd_data  in  32  storage read data, valid 1 cycle after o_rd_addr
- o_tx_data  out  8  ASCII byte to UART TX
- o_tx_valid  out  1  byte valid
- i_tx_ready  in  1  UART TX accepts the byte when valid&&ready
- o_busy  out  1  high from accepted start until done/error
- o_done  out  1  one-cycle pulse after the final LF is accepted
- o_error  out  1  one-cycle pulse on illegal dimensions

Behaviour:
- Reset values: o_rd_addr=0, o_tx_data=0, o_tx_valid=0, o_busy=0, o_done=0, o_error=0; FSM in IDLE.
- Start:
  - i_start in IDLE latches base, m and n, then moves to CHECK.
  - i_start is ignored in every other state.
- CHECK: if m==0, n==0, m>MAX_DIM or n>MAX_DIM, pulse o_error, emit nothing, and return to IDLE. Otherwise clear the row and column counters, set the address to base, and go to RD_REQ.
- Storage read:
  - RD_REQ drives o_rd_addr, then goes to RD_WAIT (1 cycle).
  - RD_WAIT captures i_rd_data[15:0] as a signed value, then goes to CONV.
- CONV (conversion):
  - Take the magnitude of the value; set a sign flag if negative.
  - Produce digits by sequential subtraction of 10000, 1000, 100, 10, 1 (at most 9 subtractions per digit, one per cycle).
  - Leading zeros are suppressed; value 0 emits a single "0".
  - -32768 must print "-32768"; the magnitude is held in 17 bits.
- Emit order per element:
  - '-' (0x2D) if negative, then digits ('0'+d).
  - Then ' ' (0x20) if not the last column, else CR (0x0D) followed by LF (0x0A).
- Handshake:
  - o_tx_data is stable while o_tx_valid=1 and !i_tx_ready.
  - o_tx_valid never drops without acceptance.
  - At most one byte is accepted per cycle.
  - The next byte may be presented the cycle after acceptance.
- Advance: after a separator or LF is accepted, increment the column counter. At column n-1, clear the column and increment the row. Increment the address and return to RD_REQ. After the LF of row m-1, go to DONE.
- DONE: pulse o_done, clear o_busy, return to IDLE.
- o_busy is high in every non-IDLE state except the cycle it returns to IDLE.
- Reset mid-operation: reset at any point returns to IDLE immediately with all outputs at reset values. A partial byte stream is discarded; no done is issued.
- Storage data must not change between RD_REQ and RD_WAIT; the mux grants the display path for the whole busy window.

Decomposition:
- Shared package holds:
  - ASCII constants: ASCII_ZERO, ASCII_MINUS, ASCII_SPACE, ASCII_CR, ASCII_LF.
  - The FSM state encoding.
  - MAX_DIM.
- One sub-module: dec_digit_gen. It loads a 17-bit magnitude and yields the digits most-significant first with a digit_valid/digit_ack handshake and a last flag. It implements subtractive conversion and leading-zero suppression.

Test Plan:
- 2x3 matrix at base 0x010 = {1,2,3; 4,5,6}, i_tx_ready=1 -> bytes "1 2 3\r\n4 5 6\r\n"; reads at 0x010..0x015; o_done pulses once.
- 1x2 matrix {-32768, 0} -> "-32768 0\r\n".
- 1x1 matrix {10050} -> "10050\r\n" (internal zeros kept).
- i_m=0, i_n=3, and separately i_m=6, i_n=1 -> o_error pulse, o_tx_valid stays 0, o_busy back to 0 within 2 cycles.
- 1x2 matrix {7,-9} with i_tx_ready toggled randomly -> same byte sequence "7 -9\r\n"; o_tx_data stable while stalled; no dropped or duplicated bytes.
- Assert rst_n=0 mid-row of a 3x3 transfer, then restart with a 1x1 matrix {42} -> outputs at reset values; new transfer emits "42\r\n" only.

Source files
------------

// File: rtl/matrix_tx_formatter_pkg.sv
// Shared constants, FSM encoding and helpers for the matrix text formatter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package matrix_tx_formatter_pkg;

  localparam int unsigned MAX_DIM = 5;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CHECK,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_CONV,
    ST_SIGN,
    ST_DIGIT,
    ST_SEP,
    ST_CR,
    ST_LF,
    ST_DONE
  } fmt_state_e;

  // Decimal weight of digit position idx, most significant (10000) first.
  function automatic logic [16:0] place_weight(input logic [2:0] idx);
    logic [16:0] w;
    case (idx)
      3'd0:    w = 17'd10000;
      3'd1:    w = 17'd1000;
      3'd2:    w = 17'd100;
      3'd3:    w = 17'd10;
      default: w = 17'd1;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/matrix_tx_formatter_dec_digit_gen.sv
// Subtractive binary-to-decimal digit generator, digits most-significant first.
// Latency: one cycle per subtraction (<=9 per digit) plus one cycle per digit.
// Backpressure: a presented digit is held until i_digit_ack; conversion pauses meanwhile.
module dec_digit_gen
  import matrix_tx_formatter_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_load,
  input  logic [16:0] i_mag,
  output logic        o_digit_vld,
  output logic [3:0]  o_digit,
  output logic        o_digit_last,
  input  logic        i_digit_ack
);

  logic        run_q, run_d;
  logic [16:0] rem_q, rem_d;
  logic [2:0]  place_q, place_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        started_q, started_d;
  logic        vld_q, vld_d;
  logic [16:0] weight;

  assign weight       = place_weight(place_q);
  assign o_digit_vld  = vld_q;
  assign o_digit      = cnt_q;
  assign o_digit_last = (place_q == 3'd4);

  // Digit state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q     <= 1'b0;
      rem_q     <= '0;
      place_q   <= '0;
      cnt_q     <= '0;
      started_q <= 1'b0;
      vld_q     <= 1'b0;
    end else begin
      run_q     <= run_d;
      rem_q     <= rem_d;
      place_q   <= place_d;
      cnt_q     <= cnt_d;
      started_q <= started_d;
      vld_q     <= vld_d;
    end
  end

  // One subtraction or one digit decision per cycle; leading zeros are
  // skipped until a nonzero digit appears, but the units digit always shows.
  always_comb begin
    run_d     = run_q;
    rem_d     = rem_q;
    place_d   = place_q;
    cnt_d     = cnt_q;
    started_d = started_q;
    vld_d     = vld_q;
    if (i_load) begin
      run_d     = 1'b1;
      rem_d     = i_mag;
      place_d   = 3'd0;
      cnt_d     = 4'd0;
      started_d = 1'b0;
      vld_d     = 1'b0;
    end else if (run_q) begin
      if (vld_q) begin
        if (i_digit_ack) begin
          vld_d     = 1'b0;
          started_d = 1'b1;
          cnt_d     = 4'd0;
          if (place_q == 3'd4) run_d = 1'b0;
          else                 place_d = place_q + 3'd1;
        end
      end else if ((rem_q >= weight) && (cnt_q < 4'd9)) begin
        rem_d = rem_q - weight;
        cnt_d = cnt_q + 4'd1;
      end else if ((cnt_q != 4'd0) || started_q || (place_q == 3'd4)) begin
        vld_d = 1'b1;
      end else begin
        place_d = place_q + 3'd1;
      end
    end
  end

endmodule

// File: rtl/matrix_tx_formatter.sv
// Reads an m x n matrix from storage and streams it as ASCII decimal text, rows ended by CR LF.
// Latency: 3 cycles from start to first read; per element read + conversion + bytes.
// Backpressure: valid/ready on the TX byte; byte and state hold while i_tx_ready is low.
module matrix_tx_formatter #(
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 32,
  parameter int MAX_DIM = matrix_tx_formatter_pkg::MAX_DIM
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [2:0]        i_m,
  input  logic [2:0]        i_n,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic [DATA_W-1:0] i_rd_data,
  output logic [7:0]        o_tx_data,
  output logic              o_tx_valid,
  input  logic              i_tx_ready,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_error
);
  import matrix_tx_formatter_pkg::*;

  localparam logic [2:0] MAX_DIM_L = 3'(MAX_DIM);

  fmt_state_e        state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        m_q, m_d, n_q, n_d;
  logic [2:0]        row_q, row_d, col_q, col_d;
  logic [15:0]       val_q, val_d;

  logic              dims_bad;
  logic [16:0]       mag;
  logic              dg_load, dg_ack, dg_vld, dg_last;
  logic [3:0]        dg_digit;
  logic              unused_rd_hi;

  // Only the low half-word carries the element value.
  assign unused_rd_hi = ^i_rd_data[DATA_W-1:16];
  assign o_rd_addr    = addr_q;
  assign dims_bad     = (m_q == 3'd0) || (n_q == 3'd0) ||
                        (m_q > MAX_DIM_L) || (n_q > MAX_DIM_L);
  // 17 bits so that -32768 has a representable magnitude.
  assign mag          = val_q[15] ? (17'd0 - {val_q[15], val_q}) : {1'b0, val_q};

  dec_digit_gen u_digits (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_load       (dg_load),
    .i_mag        (mag),
    .o_digit_vld  (dg_vld),
    .o_digit      (dg_digit),
    .o_digit_last (dg_last),
    .i_digit_ack  (dg_ack)
  );

  // Control and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      base_q  <= '0;
      addr_q  <= '0;
      m_q     <= '0;
      n_q     <= '0;
      row_q   <= '0;
      col_q   <= '0;
      val_q   <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      addr_q  <= addr_d;
      m_q     <= m_d;
      n_q     <= n_d;
      row_q   <= row_d;
      col_q   <= col_d;
      val_q   <= val_d;
    end
  end

  // Next state and outputs; outputs are decoded from the current state so a
  // stalled byte stays put until it is accepted.
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    addr_d     = addr_q;
    m_d        = m_q;
    n_d        = n_q;
    row_d      = row_q;
    col_d      = col_q;
    val_d      = val_q;
    o_tx_valid = 1'b0;
    o_tx_data  = 8'h00;
    o_busy     = (state_q != ST_IDLE);
    o_done     = 1'b0;
    o_error    = 1'b0;
    dg_load    = 1'b0;
    dg_ack     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          base_d  = i_base_addr;
          m_d     = i_m;
          n_d     = i_n;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (dims_bad) begin
          o_error = 1'b1;
          o_busy  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          row_d   = 3'd0;
          col_d   = 3'd0;
          addr_d  = base_q;
          state_d = ST_RD_REQ;
        end
      end
      ST_RD_REQ:  state_d = ST_RD_WAIT;
      ST_RD_WAIT: begin
        val_d   = i_rd_data[15:0];
        state_d = ST_CONV;
      end
      ST_CONV: begin
        dg_load = 1'b1;
        state_d = val_q[15] ? ST_SIGN : ST_DIGIT;
      end
      ST_SIGN: begin
        o_tx_valid = 1'b1;
        o_tx_data  = ASCII_MINUS;
        if (i_tx_ready) state_d = ST_DIGIT;
      end
      ST_DIGIT: begin
        o_tx_valid = dg_vld;
        o_tx_data  = ASCII_ZERO + {4'd0, dg_digit};
        if (dg_vld && i_tx_ready) begin
          dg_ack = 1'b1;
          if (dg_last) state_d = (col_q == n_q - 3'd1) ? ST_CR : ST_SEP;
        end
      end
      ST_SEP: begin
        o_tx_valid = 1'b1;
        o_tx_data  = ASCII_SPACE;
        if (i_tx_ready) begin
          col_d   = col_q + 3'd1;
          addr_d  = addr_q + 1'b1;
          state_d = ST_RD_REQ;
        end
      end
      ST_CR: begin
        o_tx_valid = 1'b1;
        o_tx_data  = ASCII_CR;
        if (i_tx_ready) state_d = ST_LF;
      end
      ST_LF: begin
        o_tx_valid = 1'b1;
        o_tx_data  = ASCII_LF;
        if (i_tx_ready) begin
          col_d = 3'd0;
          if (row_q == m_q - 3'd1) begin
            state_d = ST_DONE;
          end else begin
            row_d   = row_q + 3'd1;
            addr_d  = addr_q + 1'b1;
            state_d = ST_RD_REQ;
          end
        end
      end
      ST_DONE: begin
        o_done  = 1'b1;
        o_busy  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_matrix_tx_formatter.sv
// Directed bench for matrix_tx_formatter: storage model, byte collector, stall monitor.
// Latency: n/a.
// Backpressure: i_tx_ready is held high or toggled pseudo-randomly per test.
module tb_matrix_tx_formatter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_start;
  logic [8:0]  i_base_addr;
  logic [2:0]  i_m, i_n;
  logic [8:0]  o_rd_addr;
  logic [31:0] i_rd_data;
  logic [7:0]  o_tx_data;
  logic        o_tx_valid, i_tx_ready, o_busy, o_done, o_error;

  logic [31:0] mem [0:511];

  int          n_checks = 0;
  int          n_pass   = 0;
  int          done_cnt = 0;
  int          err_cnt  = 0;
  int          vld_cnt  = 0;
  bit          rand_rdy = 1'b0;
  bit          stall_prev = 1'b0;
  logic [7:0]  data_prev  = 8'h00;
  byte unsigned rx_q[$];
  logic [8:0]  addr_log[$];

  always #5 clk = ~clk;

  matrix_tx_formatter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_start     (i_start),
    .i_base_addr (i_base_addr),
    .i_m         (i_m),
    .i_n         (i_n),
    .o_rd_addr   (o_rd_addr),
    .i_rd_data   (i_rd_data),
    .o_tx_data   (o_tx_data),
    .o_tx_valid  (o_tx_valid),
    .i_tx_ready  (i_tx_ready),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_error     (o_error)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Synchronous-read storage: data valid one cycle after the address.
  always @(posedge clk) i_rd_data <= mem[o_rd_addr];

  // TX sink ready: either always ready or a coin flip each cycle.
  initial begin
    i_tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      i_tx_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Collector and handshake monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("stall_valid_held", 32'(o_tx_valid), 32'd1);
        chk("stall_data_held", 32'(o_tx_data), 32'(data_prev));
      end
      if (o_tx_valid && i_tx_ready) rx_q.push_back(o_tx_data);
      if (o_done)     done_cnt++;
      if (o_error)    err_cnt++;
      if (o_tx_valid) vld_cnt++;
      if (o_busy && (addr_log.size() == 0 || addr_log[$] != o_rd_addr))
        addr_log.push_back(o_rd_addr);
      stall_prev = o_tx_valid && !i_tx_ready;
      data_prev  = o_tx_data;
    end
  end

  task automatic start_mat(input logic [8:0] b, input logic [2:0] m, input logic [2:0] n);
    @(posedge clk);
    #2;
    i_base_addr = b;
    i_m         = m;
    i_n         = n;
    i_start     = 1'b1;
    @(posedge clk);
    #2;
    i_start = 1'b0;
  endtask

  task automatic run_mat(input string name, input logic [8:0] b, input logic [2:0] m,
                         input logic [2:0] n, input string exp);
    int d0;
    bit seen;
    d0   = done_cnt;
    seen = 1'b0;
    rx_q.delete();
    addr_log.delete();
    start_mat(b, m, n);
    for (int c = 0; c < 3000 && !seen; c++) begin
      @(negedge clk);
      if (o_done) seen = 1'b1;
    end
    chk({name, "_done_seen"}, 32'(seen), 32'd1);
    repeat (3) @(negedge clk);
    chk({name, "_done_once"}, 32'(done_cnt - d0), 32'd1);
    chk({name, "_busy_low"}, 32'(o_busy), 32'd0);
    chk({name, "_byte_count"}, 32'(rx_q.size()), 32'(exp.len()));
    for (int i = 0; i < exp.len(); i++)
      if (i < rx_q.size()) chk({name, "_byte"}, 32'(rx_q[i]), 32'(exp[i]));
  endtask

  task automatic run_err(input string name, input logic [2:0] m, input logic [2:0] n);
    int e0;
    int v0;
    e0 = err_cnt;
    v0 = vld_cnt;
    start_mat(9'h000, m, n);
    repeat (2) @(negedge clk);
    chk({name, "_busy_low"}, 32'(o_busy), 32'd0);
    repeat (2) @(negedge clk);
    chk({name, "_error_once"}, 32'(err_cnt - e0), 32'd1);
    chk({name, "_no_tx"}, 32'(vld_cnt - v0), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_rd_addr"}, 32'(o_rd_addr), 32'd0);
    chk({name, "_tx_data"}, 32'(o_tx_data), 32'd0);
    chk({name, "_tx_valid"}, 32'(o_tx_valid), 32'd0);
    chk({name, "_busy"}, 32'(o_busy), 32'd0);
    chk({name, "_done"}, 32'(o_done), 32'd0);
    chk({name, "_error"}, 32'(o_error), 32'd0);
  endtask

  initial begin
    int d0;
    rst_n       = 1'b1;
    i_start     = 1'b0;
    i_base_addr = '0;
    i_m         = '0;
    i_n         = '0;
    for (int a = 0; a < 512; a++) mem[a] = 32'd0;
    #3 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    @(posedge clk);
    #2 rst_n = 1'b1;

    // 2x3 positive matrix, continuous ready
    for (int a = 0; a < 6; a++) mem[9'h010 + a] = 32'(a + 1);
    run_mat("m2x3", 9'h010, 3'd2, 3'd3, "1 2 3\015\0124 5 6\015\012");
    chk("m2x3_addr_count", 32'(addr_log.size()), 32'd7);
    for (int i = 1; i < 7; i++)
      if (i < addr_log.size()) chk("m2x3_rd_addr", 32'(addr_log[i]), 32'(9'h010 + i - 1));

    // most negative value and zero
    mem[9'h020] = 32'hFFFF_8000;
    mem[9'h021] = 32'h0000_0000;
    run_mat("neg_zero", 9'h020, 3'd1, 3'd2, "-32768 0\015\012");

    // internal zeros preserved
    mem[9'h030] = 32'd10050;
    run_mat("internal_zero", 9'h030, 3'd1, 3'd1, "10050\015\012");

    // illegal dimensions
    run_err("err_m0", 3'd0, 3'd3);
    run_err("err_m6", 3'd6, 3'd1);

    // random backpressure
    mem[9'h038] = 32'd7;
    mem[9'h039] = 32'hFFFF_FFF7;
    rand_rdy = 1'b1;
    run_mat("stall", 9'h038, 3'd1, 3'd2, "7 -9\015\012");
    rand_rdy = 1'b0;
    repeat (2) @(negedge clk);

    // reset mid-row of a 3x3, then a fresh 1x1
    for (int a = 0; a < 9; a++) mem[9'h040 + a] = 32'(111 * (a + 1));
    mem[9'h080] = 32'd42;
    rx_q.delete();
    d0 = done_cnt;
    start_mat(9'h040, 3'd3, 3'd3);
    for (int c = 0; c < 2000 && rx_q.size() < 5; c++) @(negedge clk);
    chk("midrst_reached", 32'(rx_q.size() >= 5), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    repeat (3) @(negedge clk);
    chk("midrst_no_done", 32'(done_cnt - d0), 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    run_mat("after_rst", 9'h080, 3'd1, 3'd1, "42\015\012");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
